// File: rtl/row_max_align_if.sv
// row_max_align_if: beat-in / aligned-beat-out bundle for row_max_align.
// slave is the block side, master is the producer/consumer side.
interface row_max_align_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 64,
  parameter int CNT_W  = 4
);
  logic                     i_en;
  logic                     i_valid;
  logic [CNT_W-1:0]         i_beats;
  logic signed [DATA_W-1:0] i_beat_max;
  logic [LANES*DATA_W-1:0]  i_data;

  logic                     o_valid;
  logic [LANES*DATA_W-1:0]  o_data;
  logic signed [DATA_W-1:0] o_row_max;
  logic                     o_first;
  logic                     o_last;
  logic                     o_err;
  logic                     o_cfg_err;

  modport slave (
    input  i_en,
    input  i_valid,
    input  i_beats,
    input  i_beat_max,
    input  i_data,
    output o_valid,
    output o_data,
    output o_row_max,
    output o_first,
    output o_last,
    output o_err,
    output o_cfg_err
  );

  modport master (
    output i_en,
    output i_valid,
    output i_beats,
    output i_beat_max,
    output i_data,
    input  o_valid,
    input  o_data,
    input  o_row_max,
    input  o_first,
    input  o_last,
    input  o_err,
    input  o_cfg_err
  );
endinterface

// File: rtl/row_max_align.sv
// row_max_align: signed running row max back-annotated onto a D-deep beat pipe.
// Define ROW_MAX_ALIGN_ERR_EN to build o_err / o_cfg_err reporting.
module row_max_align #(
  parameter int DATA_W    = 16,
  parameter int LANES     = 64,
  parameter int MAX_BEATS = 12,
  parameter int CNT_W     = $clog2(MAX_BEATS+1)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  row_max_align_if.slave bus
);
  localparam int D  = MAX_BEATS;
  localparam int PW = LANES*DATA_W;
  localparam logic signed [DATA_W-1:0] MIN =
    {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] LMAX = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [D-1:0] vld_q, vld_d;
  logic [D-1:0] opn_q, opn_d;
  logic [D-1:0] fst_q, fst_d;
  logic [D-1:0] lst_q, lst_d;
  logic [PW-1:0] dat_q [D];
  logic [PW-1:0] dat_d [D];
  logic signed [DATA_W-1:0] max_q [D];
  logic signed [DATA_W-1:0] max_d [D];

  logic signed [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;

  logic first;
  logic legal;
  logic comp;
  logic early;
  logic [CNT_W-1:0] len_eff;
  logic signed [DATA_W-1:0] base;
  logic signed [DATA_W-1:0] w_max;
  logic signed [DATA_W-1:0] w_part;

  // Row bookkeeping seen by the beat arriving this cycle.
  always_comb begin
    first   = (cnt_q == '0);
    legal   = (bus.i_beats != '0) && (bus.i_beats <= LMAX);
    len_eff = len_q;
    if (first) len_eff = legal ? bus.i_beats : LMAX;
    base    = first ? MIN : acc_q;
    w_max   = base;
    if ($signed(bus.i_beat_max) > $signed(base))
      w_max = bus.i_beat_max;
    w_part  = bus.i_valid ? w_max : acc_q;
    comp    = bus.i_valid && (cnt_q == (len_eff - ONE));
    early   = opn_q[D-2] && !comp;
  end

  always_comb begin
    vld_d = vld_q;
    opn_d = opn_q;
    fst_d = fst_q;
    lst_d = lst_q;
    dat_d = dat_q;
    max_d = max_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    len_d = len_q;

    vld_d[0] = bus.i_valid;
    opn_d[0] = bus.i_valid && !comp;
    fst_d[0] = bus.i_valid && first;
    lst_d[0] = bus.i_valid && comp;
    dat_d[0] = bus.i_data;
    max_d[0] = bus.i_valid ? w_max : MIN;

    for (int k = 1; k < D; k++) begin
      vld_d[k] = vld_q[k-1];
      opn_d[k] = opn_q[k-1];
      fst_d[k] = fst_q[k-1];
      lst_d[k] = lst_q[k-1];
      dat_d[k] = dat_q[k-1];
      max_d[k] = max_q[k-1];
      if (opn_q[k-1] && comp) begin
        max_d[k] = w_max;
        opn_d[k] = 1'b0;
      end
    end

    // Open beat leaving before its row closes takes the partial max.
    if (early) begin
      max_d[D-1] = w_part;
      opn_d[D-1] = 1'b0;
    end

    if (bus.i_valid) begin
      if (first) len_d = len_eff;
      if (comp) begin
        cnt_d = '0;
        acc_d = MIN;
      end else begin
        cnt_d = cnt_q + ONE;
        acc_d = w_max;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q <= '0;
      opn_q <= '0;
      fst_q <= '0;
      lst_q <= '0;
      for (int k = 0; k < D; k++) begin
        dat_q[k] <= '0;
        max_q[k] <= MIN;
      end
      acc_q <= MIN;
      cnt_q <= '0;
      len_q <= LMAX;
    end else if (bus.i_en) begin
      vld_q <= vld_d;
      opn_q <= opn_d;
      fst_q <= fst_d;
      lst_q <= lst_d;
      for (int k = 0; k < D; k++) begin
        dat_q[k] <= dat_d[k];
        max_q[k] <= max_d[k];
      end
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
    end
  end

  assign bus.o_valid   = vld_q[D-1];
  assign bus.o_data    = dat_q[D-1];
  assign bus.o_row_max = max_q[D-1];
  assign bus.o_first   = fst_q[D-1];
  assign bus.o_last    = lst_q[D-1];

`ifdef ROW_MAX_ALIGN_ERR_EN
  logic err_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_q <= 1'b0;
    end else if (bus.i_en) begin
      err_q <= early;
    end
  end

  assign bus.o_err     = err_q;
  assign bus.o_cfg_err = !i_rst && bus.i_en && bus.i_valid &&
                         first && !legal;
`else
  assign bus.o_err     = 1'b0;
  assign bus.o_cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_row_max_align.sv
// tb_row_max_align: directed row scenarios plus random traffic
// checked against a row-level reference model.
`timescale 1ns/1ps
module tb_row_max_align;
  localparam int DW = 16;
  localparam int LN = 64;
  localparam int D  = 12;
  localparam int CW = $clog2(D+1);
  localparam int NR = 1024;
  localparam logic signed [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};
`ifdef ROW_MAX_ALIGN_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  row_max_align_if #(.DATA_W(DW), .LANES(LN), .CNT_W(CW)) bus ();

  row_max_align #(
    .DATA_W(DW), .LANES(LN), .MAX_BEATS(D), .CNT_W(CW)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: every accepted advance is logged; a row's final max
  // is the plain maximum over its beats once its last beat has arrived.
  int adv, cur_cnt, cur_len, cur_row, nrows;
  logic r_vld [NR];
  logic r_fst [NR];
  logic r_lst [NR];
  int r_row [NR];
  logic signed [DW-1:0] r_max [NR];
  logic [LN*DW-1:0] r_dat [NR];
  int row_done [NR];
  logic signed [DW-1:0] row_fmax [NR];

  logic exp_v, exp_f, exp_l, exp_e, exp_cfg, act_cfg;
  logic signed [DW-1:0] exp_m;
  logic [LN*DW-1:0] exp_d;

  function automatic logic signed [DW-1:0] row_peak(int row, int upto);
    logic signed [DW-1:0] m;
    m = MINV;
    for (int i = 0; i <= upto; i++)
      if (r_vld[i] && r_row[i] == row && r_max[i] > m) m = r_max[i];
    return m;
  endfunction

  function automatic void predict();
    int e;
    e = adv - D;
    exp_v = 1'b0; exp_f = 1'b0; exp_l = 1'b0; exp_e = 1'b0;
    exp_m = MINV; exp_d = '0;
    if (e >= 0 && r_vld[e]) begin
      exp_v = 1'b1;
      exp_f = r_fst[e];
      exp_l = r_lst[e];
      exp_d = r_dat[e];
      if (row_done[r_row[e]] >= 0) begin
        exp_m = row_fmax[r_row[e]];
      end else begin
        exp_m = row_peak(r_row[e], adv - 1);
        exp_e = ERR_EN;
      end
    end
  endfunction

  task automatic cyc(input logic en, input logic v,
                     input logic [CW-1:0] nb,
                     input logic signed [DW-1:0] bm);
    logic [LN*DW-1:0] d;
    for (int i = 0; i < LN; i++) d[i*DW +: DW] = DW'($urandom);
    bus.i_en = en;
    bus.i_valid = v;
    bus.i_beats = nb;
    bus.i_beat_max = bm;
    bus.i_data = d;
    exp_cfg = ERR_EN && !rst && en && v && cur_cnt == 0 &&
              (nb == 0 || int'(nb) > D);
    #1 act_cfg = bus.o_cfg_err;
    @(posedge clk);
    if (rst) begin
      adv = 0; cur_cnt = 0; nrows = 0;
    end else if (en) begin
      r_vld[adv] = v; r_fst[adv] = 1'b0; r_lst[adv] = 1'b0;
      r_dat[adv] = d; r_max[adv] = bm; r_row[adv] = -1;
      if (v) begin
        if (cur_cnt == 0) begin
          cur_row = nrows; nrows++;
          cur_len = (nb == 0 || int'(nb) > D) ? D : int'(nb);
          row_done[cur_row] = -1;
          r_fst[adv] = 1'b1;
        end
        r_row[adv] = cur_row;
        cur_cnt++;
        if (cur_cnt == cur_len) begin
          r_lst[adv] = 1'b1;
          cur_cnt = 0;
          row_done[cur_row] = adv;
          row_fmax[cur_row] = row_peak(cur_row, adv);
        end
      end
      adv++;
    end
    @(negedge clk);
    predict();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b1, 1'b0, '0, '0);
    cyc(1'b1, 1'b0, '0, '0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 14; c++) cyc(1'b1, 1'b1, CW'(1), DW'(c));
    rst = 1'b1;
    cyc(1'b1, 1'b1, CW'(0), DW'(5));
    rst = 1'b0;
    n_chk++;
    if (bus.o_valid !== 1'b0 || bus.o_first !== 1'b0 ||
        bus.o_last !== 1'b0 || bus.o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: v=%b f=%b l=%b err=%b, want all 0",
               bus.o_valid, bus.o_first, bus.o_last, bus.o_err);
    end
    n_chk++;
    if (bus.o_row_max !== MINV) begin
      n_fail++;
      $display("FAIL reset_max: got %h want %h", bus.o_row_max, MINV);
    end
    n_chk++;
    if (bus.o_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got nonzero, want 0");
    end
    n_chk++;
    if (act_cfg !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cfg: got %b want 0", act_cfg);
    end
  endtask

  task automatic test_basic();
    int bm [4] = '{3, -7, 20, 5};
    logic signed [DW-1:0] want;
    int k = 0;
    want = DW'(20);
    do_reset();
    for (int c = 0; c < 20; c++) begin
      if (c < 4) cyc(1'b1, 1'b1, CW'(4), DW'(bm[c]));
      else cyc(1'b1, 1'b0, '0, '0);
      if (bus.o_valid === 1'b1) begin
        n_chk++;
        if (bus.o_row_max !== want || bus.o_err !== 1'b0 ||
            bus.o_first !== (k == 0) || bus.o_last !== (k == 3) ||
            adv != D + k || bus.o_data !== r_dat[k]) begin
          n_fail++;
          $display("FAIL basic beat %0d: max=%0d err=%b f=%b l=%b adv=%0d, want max=20 err=0 f=%b l=%b adv=%0d",
                   k, bus.o_row_max, bus.o_err, bus.o_first, bus.o_last,
                   adv, k == 0, k == 3, D + k);
        end
        k++;
      end
    end
    n_chk++;
    if (k != 4) begin
      n_fail++;
      $display("FAIL basic_count: got %0d want 4", k);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [DW-1:0] want;
    int k = 0;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      if (c == 0) cyc(1'b1, 1'b1, CW'(1), DW'(-100));
      else if (c == 1) cyc(1'b1, 1'b1, CW'(12), DW'(0));
      else if (c < 13)
        cyc(1'b1, 1'b1, CW'($urandom_range(0, 15)), DW'(c - 1));
      else cyc(1'b1, 1'b0, '0, '0);
      if (bus.o_valid === 1'b1) begin
        want = (k == 0) ? DW'(-100) : DW'(11);
        n_chk++;
        if (bus.o_row_max !== want || bus.o_err !== 1'b0 ||
            bus.o_first !== (k <= 1) || bus.o_last !== (k == 0 || k == 12) ||
            adv != D + k) begin
          n_fail++;
          $display("FAIL b2b beat %0d: max=%0d err=%b f=%b l=%b adv=%0d, want max=%0d err=0 f=%b l=%b adv=%0d",
                   k, bus.o_row_max, bus.o_err, bus.o_first, bus.o_last,
                   adv, want, k <= 1, k == 0 || k == 12, D + k);
        end
        k++;
      end
    end
    n_chk++;
    if (k != 13) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d want 13", k);
    end
  endtask

  task automatic test_bubbles();
    int wm [3] = '{50, 60, 60};
    logic signed [DW-1:0] want;
    logic we;
    int k = 0;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      if (c == 0) cyc(1'b1, 1'b1, CW'(3), DW'(50));
      else if (c == 12) cyc(1'b1, 1'b1, CW'(0), DW'(60));
      else if (c == 13) cyc(1'b1, 1'b1, CW'(9), DW'(40));
      else cyc(1'b1, 1'b0, '0, '0);
      if (bus.o_valid === 1'b1) begin
        n_chk++;
        if (k < 3) begin
          want = DW'(wm[k]);
          we = (k == 0) ? ERR_EN : 1'b0;
          if (bus.o_row_max !== want || bus.o_err !== we ||
              bus.o_first !== (k == 0) || bus.o_last !== (k == 2)) begin
            n_fail++;
            $display("FAIL bubble beat %0d: max=%0d err=%b f=%b l=%b, want max=%0d err=%b f=%b l=%b",
                     k, bus.o_row_max, bus.o_err, bus.o_first, bus.o_last,
                     want, we, k == 0, k == 2);
          end
        end else begin
          n_fail++;
          $display("FAIL bubble_extra: beat %0d got, want none", k);
        end
        k++;
      end
    end
    n_chk++;
    if (k != 3) begin
      n_fail++;
      $display("FAIL bubble_count: got %0d want 3", k);
    end
  endtask

  task automatic test_cfg_min();
    logic wc;
    int k = 0;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      if (c == 0) cyc(1'b1, 1'b1, CW'(0), MINV);
      else if (c < 12) cyc(1'b1, 1'b1, CW'($urandom_range(1, 15)), MINV);
      else cyc(1'b1, 1'b0, '0, '0);
      if (c < 12) begin
        wc = (c == 0) ? ERR_EN : 1'b0;
        n_chk++;
        if (act_cfg !== wc) begin
          n_fail++;
          $display("FAIL cfg_pulse cyc %0d: got %b want %b", c, act_cfg, wc);
        end
      end
      if (bus.o_valid === 1'b1) begin
        n_chk++;
        if (bus.o_row_max !== MINV || bus.o_err !== 1'b0 ||
            bus.o_first !== (k == 0) || bus.o_last !== (k == 11)) begin
          n_fail++;
          $display("FAIL cfg_min beat %0d: max=%h err=%b f=%b l=%b, want max=%h err=0 f=%b l=%b",
                   k, bus.o_row_max, bus.o_err, bus.o_first, bus.o_last,
                   MINV, k == 0, k == 11);
        end
        k++;
      end
    end
    n_chk++;
    if (k != 12) begin
      n_fail++;
      $display("FAIL cfg_min_count: got %0d want 12", k);
    end
  endtask

  task automatic test_enable();
    logic signed [DW-1:0] want;
    int k = 0;
    want = DW'(10);
    do_reset();
    for (int c = 0; c < 30; c++) begin
      if (c == 0 || (c >= 3 && c <= 7)) cyc(1'b0, 1'b1, CW'(0), DW'(127));
      else if (c == 1) cyc(1'b1, 1'b1, CW'(4), DW'(10));
      else if (c == 2) cyc(1'b1, 1'b1, CW'(1), DW'(-3));
      else if (c == 8) cyc(1'b1, 1'b1, CW'(2), DW'(7));
      else if (c == 9) cyc(1'b1, 1'b1, CW'(0), DW'(2));
      else cyc(1'b1, 1'b0, '0, '0);
      if (c == 0) begin
        n_chk++;
        if (act_cfg !== 1'b0) begin
          n_fail++;
          $display("FAIL en_cfg_frozen: got %b want 0", act_cfg);
        end
      end
      if (bus.o_valid === 1'b1) begin
        n_chk++;
        if (bus.o_row_max !== want || bus.o_err !== 1'b0 ||
            bus.o_first !== (k == 0) || bus.o_last !== (k == 3) ||
            c != k + D + 5) begin
          n_fail++;
          $display("FAIL enable beat %0d: max=%0d err=%b f=%b l=%b cyc=%0d, want max=10 err=0 f=%b l=%b cyc=%0d",
                   k, bus.o_row_max, bus.o_err, bus.o_first, bus.o_last,
                   c, k == 0, k == 3, k + D + 5);
        end
        k++;
      end
    end
    n_chk++;
    if (k != 4) begin
      n_fail++;
      $display("FAIL enable_count: got %0d want 4", k);
    end
  endtask

  task automatic test_mid_reset();
    logic signed [DW-1:0] want;
    int k = 0;
    want = DW'(2);
    do_reset();
    cyc(1'b1, 1'b1, CW'(4), DW'(9));
    cyc(1'b1, 1'b1, CW'(4), DW'(8));
    rst = 1'b1;
    cyc(1'b1, 1'b1, CW'(4), DW'(100));
    rst = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (c == 0) cyc(1'b1, 1'b1, CW'(2), DW'(1));
      else if (c == 1) cyc(1'b1, 1'b1, CW'(7), DW'(2));
      else cyc(1'b1, 1'b0, '0, '0);
      if (bus.o_valid === 1'b1) begin
        n_chk++;
        if (bus.o_row_max !== want || bus.o_err !== 1'b0 ||
            bus.o_first !== (k == 0) || bus.o_last !== (k == 1)) begin
          n_fail++;
          $display("FAIL midrst beat %0d: max=%0d err=%b f=%b l=%b, want max=2 err=0 f=%b l=%b",
                   k, bus.o_row_max, bus.o_err, bus.o_first, bus.o_last,
                   k == 0, k == 1);
        end
        k++;
      end
    end
    n_chk++;
    if (k != 2) begin
      n_fail++;
      $display("FAIL midrst_count: got %0d want 2", k);
    end
  endtask

  task automatic test_random();
    logic en, v;
    logic [CW-1:0] nb;
    logic signed [DW-1:0] bm;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      en = ($urandom_range(0, 9) != 0);
      v  = ($urandom_range(0, 3) != 0);
      nb = CW'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: bm = MINV;
        1: bm = 16'sh7fff;
        2: bm = DW'(int'($urandom_range(0, 20)) - 10);
        default: bm = DW'($urandom);
      endcase
      cyc(en, v, nb, bm);
      n_chk++;
      if (bus.o_valid !== exp_v) begin
        n_fail++;
        $display("FAIL rand_valid cyc %0d: got %b want %b",
                 c, bus.o_valid, exp_v);
      end
      if (exp_v) begin
        n_chk++;
        if (bus.o_row_max !== exp_m || bus.o_first !== exp_f ||
            bus.o_last !== exp_l || bus.o_err !== exp_e ||
            bus.o_data !== exp_d) begin
          n_fail++;
          $display("FAIL rand_beat cyc %0d: max=%0d f=%b l=%b err=%b, want max=%0d f=%b l=%b err=%b data_eq=%b",
                   c, bus.o_row_max, bus.o_first, bus.o_last, bus.o_err,
                   exp_m, exp_f, exp_l, exp_e, bus.o_data === exp_d);
        end
      end
      n_chk++;
      if (act_cfg !== exp_cfg) begin
        n_fail++;
        $display("FAIL rand_cfg cyc %0d: got %b want %b",
                 c, act_cfg, exp_cfg);
      end
    end
  endtask

  initial begin
    adv = 0; cur_cnt = 0; cur_len = D; cur_row = 0; nrows = 0;
    bus.i_en = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_beats = '0;
    bus.i_beat_max = '0;
    bus.i_data = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_bubbles();
    test_cfg_min();
    test_enable();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/row_max_align.md
# row_max_align

Parametrised successor to the fixed 12-deep max-forwarding stage in the softmax-approximation datapath. It accumulates a signed running maximum over a row of LANES-wide beats, up to MAX_BEATS beats per row, with the row length selected at runtime. Each beat is delayed through a MAX_BEATS-deep pipeline, and the completed row maximum is back-annotated onto every in-flight beat of that row. Every beat therefore leaves the block paired with its final row maximum, ready for the downstream exp/subtract stage. Unlike its predecessor, it tolerates bubbles inside a row and flags beats that exit before their row completes.

## Interface
- DATA_W, 16, element width (signed two's complement)
- LANES, 64, elements per beat
- MAX_BEATS, 12, maximum beats per row; also the pipeline depth D
- CNT_W, $clog2(MAX_BEATS+1), width of the length and count fields
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_en  in  1  global advance; when low, all state freezes
- i_valid  in  1  beat present this cycle
- i_beats  in  CNT_W  row length; sampled only on a row's first beat
- i_beat_max  in  DATA_W  signed local maximum of the incoming beat
- i_data  in  LANES*DATA_W  beat payload, passed through untouched
- o_valid  out  1  output beat valid
- o_data  out  LANES*DATA_W  delayed payload
- o_row_max  out  DATA_W  row maximum associated with o_data
- o_first  out  1  output beat is beat 0 of its row
- o_last  out  1  output beat is the final beat of its row
- o_err  out  1  output beat left the block before its row completed
- o_cfg_err  out  1  one-cycle pulse: illegal i_beats sampled

## Operation
- Pipeline: D = MAX_BEATS stages, s[0..D-1]. Each stage holds {valid, open, first, last, data, max}. Outputs are driven directly from s[D-1].
- Advance on each cycle with i_en=1: s[0] loads the incoming beat (valid=i_valid), and s[k] loads s[k-1].
- Row tracking:
  - Registers: accumulator acc (reset value MIN = 1 followed by DATA_W-1 zeros), beat count cnt, latched length len.
  - First beat (cnt==0): latch len from i_beats. If i_beats==0 or i_beats>MAX_BEATS, set len=MAX_BEATS and pulse o_cfg_err.
  - Running max: w_max = signed max(cnt==0 ? MIN : acc, i_beat_max).
- Beat entry:
  - Non-final beat: acc<=w_max, cnt<=cnt+1, and the beat enters s[0] with open=1.
  - Final beat (cnt==len-1): completion event. cnt<=0, acc<=MIN, and the beat enters with open=0, last=1, max=w_max.
- On completion, every stage whose source is open loads max=w_max and clears open during the same advance.
- Bubbles (i_valid=0) enter as valid=0, open=0. acc and cnt hold.
- Early exit: an open beat moving into s[D-1] without a completion in the same cycle loads max=w_max_partial and err=1. w_max_partial is the current acc, or the max including i_beat_max if a beat arrives that cycle. That beat clears open. Later beats of the same row still complete normally.
- Simultaneous events:
  - Completion and open-beat exit in the same cycle: completion wins; the exiting beat gets the final max and err=0.
  - Length 1: the row completes on entry; first=last=1.
- Signed comparison throughout. A tie keeps the accumulator value.

## Timing
- Latency: a beat accepted at enabled cycle t appears on o_* after exactly D enabled cycles. Throughput is 1 beat per cycle.
- Guarantee: a row of L ≤ D beats arriving with no bubbles always exits with its final max and err=0.
- Reset values of all outputs: o_valid=0, o_data=0, o_row_max=MIN, o_first=0, o_last=0, o_err=0, o_cfg_err=0.
- Reset internal state: every stage has valid=0 and open=0; acc=MIN, cnt=0.
- Reset mid-row discards the partial row and all in-flight beats.
- i_en=0 freezes the pipeline, acc, cnt and len; o_cfg_err is 0 in a frozen cycle.
- i_rst has priority over i_en.

## Configuration
- ROW_MAX_ALIGN_ERR_EN defined: o_err and o_cfg_err behave as described.
- ROW_MAX_ALIGN_ERR_EN undefined:
  - o_err and o_cfg_err are tied to 0, and the err stage bit is not built.
  - Early-exit beats still carry the partial max.
  - An illegal length still clamps to MAX_BEATS.

## Test plan
- D=12. Row of 4 contiguous beats with maxes {3, -7, 20, 5}, len=4 → four output beats 12 cycles later, all with o_row_max=20, first on beat 0, last on beat 3, o_err=0.
- Back-to-back rows: len=1 beat of -100, then len=12 row with maxes 0..11 → the first output has o_row_max=-100; the next 12 outputs have 11 and o_err=0, including beat 0 of the second row, where completion coincides with exit.
- Row of len=3 with 11 bubbles between beat 0 and beat 1, maxes {50, 60, 40}:
  - beat 0 exits with o_row_max=50 and o_err=1;
  - beats 1 and 2 exit with o_row_max=60 and o_err=0.
- i_beats=0 on a first beat → o_cfg_err pulses once and the row takes 12 beats. All-MIN inputs (0x8000) → o_row_max=0x8000.
- i_en held low for 5 cycles mid-row → outputs hold, latency extends by exactly 5 cycles, maxes unchanged.
- Assert i_rst after 2 of 4 beats, then send a new len=2 row with maxes {1, 2} → only 2 outputs, both with o_row_max=2. There is no output from the aborted row.
